// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: per-stage enable/flush/bubble control for the 5-stage RV32 pipeline,
// with load-use bubbles, cache-miss freeze, MEM redirect flush and performance counters.
module hazard_stall_ctrl #(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32,
    parameter int MISS_TIMEOUT      = 1024
) (
    input  logic              muxClockCache,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              lw_ex,
    input  logic              escreg_ex,
    input  logic              redirect_mem,
    input  logic              inst_hit,
    input  logic              data_req,
    input  logic              data_hit,
    input  logic              perf_clr,
    output logic              en_pc,
    output logic              en_if_id,
    output logic              en_id_ex,
    output logic              en_ex_mem,
    output logic              en_mem_wb,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  lstall_cnt,
    output logic [CNT_W-1:0]  freeze_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              miss_timeout
);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] LSTALL = 1'b1;
    localparam int TW = $clog2(MISS_TIMEOUT + 1);

    logic [0:0]    state;
    logic [1:0]    rem;
    logic [TW-1:0] missRun;
    logic          freeze, hazard, stallNow, redirectNow;

    assign freeze = !inst_hit || (data_req && !data_hit);
    assign hazard = lw_ex && escreg_ex && (rd_ex != '0) &&
                    ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
    assign redirectNow = !freeze && redirect_mem;
    assign stallNow = !freeze && !redirect_mem && (state == LSTALL || hazard);

    assign en_pc        = !freeze && !stallNow;
    assign en_if_id     = !freeze && !stallNow;
    assign en_id_ex     = !freeze;
    assign en_ex_mem    = !freeze;
    assign en_mem_wb    = !freeze;
    assign bubble_id_ex = stallNow;
    assign flush_if_id  = redirectNow;
    assign flush_id_ex  = redirectNow;
    assign flush_ex_mem = redirectNow;

    // The hazard is only sampled in RUN; LSTALL just counts down the remaining bubbles.
    always_ff @(posedge muxClockCache or posedge reset)
        if (reset) begin
            state <= RUN;
            rem   <= '0;
        end else if (!freeze) begin
            if (redirect_mem) begin
                state <= RUN;
                rem   <= '0;
            end else if (state == LSTALL) begin
                rem   <= rem - 2'd1;
                state <= (rem == 2'd1) ? RUN : LSTALL;
            end else if (hazard && LOAD_STALL_CYCLES > 1) begin
                state <= LSTALL;
                rem   <= 2'(LOAD_STALL_CYCLES - 1);
            end
        end

    always_ff @(posedge muxClockCache or posedge reset)
        if (reset) begin
            cyc_cnt    <= '0;
            lstall_cnt <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else if (perf_clr) begin
            cyc_cnt    <= '0;
            lstall_cnt <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            cyc_cnt    <= cyc_cnt + CNT_W'(cyc_cnt != '1);
            lstall_cnt <= lstall_cnt + CNT_W'(stallNow && lstall_cnt != '1);
            freeze_cnt <= freeze_cnt + CNT_W'(freeze && freeze_cnt != '1);
            flush_cnt  <= flush_cnt + CNT_W'(redirectNow && flush_cnt != '1);
        end

    // The flag sets on the edge where the consecutive-freeze count reaches MISS_TIMEOUT.
    always_ff @(posedge muxClockCache or posedge reset)
        if (reset) begin
            missRun     <= '0;
            miss_timeout <= 1'b0;
        end else begin
            missRun      <= !freeze ? '0 : (missRun == TW'(MISS_TIMEOUT)) ? missRun : missRun + 1'b1;
            miss_timeout <= miss_timeout || (freeze && missRun == TW'(MISS_TIMEOUT - 1));
        end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks on two instances (1-cycle and 2-cycle load stall)
// sharing one stimulus; control outputs are compared as a packed 9-bit vector.
module tb_hazard_stall_ctrl;
    logic muxClockCache = 1'b0;
    logic reset = 1'b1;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic use_rs1_id, use_rs2_id, lw_ex, escreg_ex, redirect_mem;
    logic inst_hit, data_req, data_hit, perf_clr;
    logic pc1, ifid1, idex1, exmem1, memwb1, bub1, fif1, fid1, fex1, miss1;
    logic pc2, ifid2, idex2, exmem2, memwb2, bub2, fif2, fid2, fex2, miss2;
    logic [3:0]  cyc1, lst1, frz1, fl1;
    logic [15:0] cyc2, lst2, frz2, fl2;
    logic [8:0]  ctl1, ctl2;
    int checks = 0;
    int errors = 0;

    // {en_pc,en_if_id,en_id_ex,en_ex_mem,en_mem_wb,bubble,flush_if_id,flush_id_ex,flush_ex_mem}
    localparam logic [8:0] C_RUN = 9'b11111_1_000 & 9'b11111_0_111;
    localparam logic [8:0] C_STALL = 9'b00111_1_000;
    localparam logic [8:0] C_FREEZE = 9'b00000_0_000;
    localparam logic [8:0] C_REDIR = 9'b11111_0_111;

    assign ctl1 = {pc1, ifid1, idex1, exmem1, memwb1, bub1, fif1, fid1, fex1};
    assign ctl2 = {pc2, ifid2, idex2, exmem2, memwb2, bub2, fif2, fid2, fex2};

    always #5 muxClockCache = ~muxClockCache;

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4), .MISS_TIMEOUT(8)) dut1 (
        .muxClockCache(muxClockCache), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex), .lw_ex(lw_ex),
        .escreg_ex(escreg_ex), .redirect_mem(redirect_mem), .inst_hit(inst_hit),
        .data_req(data_req), .data_hit(data_hit), .perf_clr(perf_clr),
        .en_pc(pc1), .en_if_id(ifid1), .en_id_ex(idex1), .en_ex_mem(exmem1), .en_mem_wb(memwb1),
        .bubble_id_ex(bub1), .flush_if_id(fif1), .flush_id_ex(fid1), .flush_ex_mem(fex1),
        .cyc_cnt(cyc1), .lstall_cnt(lst1), .freeze_cnt(frz1), .flush_cnt(fl1), .miss_timeout(miss1));

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(16), .MISS_TIMEOUT(8)) dut2 (
        .muxClockCache(muxClockCache), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex), .lw_ex(lw_ex),
        .escreg_ex(escreg_ex), .redirect_mem(redirect_mem), .inst_hit(inst_hit),
        .data_req(data_req), .data_hit(data_hit), .perf_clr(perf_clr),
        .en_pc(pc2), .en_if_id(ifid2), .en_id_ex(idex2), .en_ex_mem(exmem2), .en_mem_wb(memwb2),
        .bubble_id_ex(bub2), .flush_if_id(fif2), .flush_id_ex(fid2), .flush_ex_mem(fex2),
        .cyc_cnt(cyc2), .lstall_cnt(lst2), .freeze_cnt(frz2), .flush_cnt(fl2), .miss_timeout(miss2));

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; lw_ex = 1'b0; escreg_ex = 1'b0;
        redirect_mem = 1'b0; inst_hit = 1'b1; data_req = 1'b0; data_hit = 1'b1; perf_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge muxClockCache);
        #1;
    endtask

    task automatic loadUse(input logic [4:0] rd);
        lw_ex = 1'b1; escreg_ex = 1'b1; rd_ex = rd; rs1_id = rd; use_rs1_id = 1'b1;
    endtask

    task automatic clearCounters();
        idle();
        tick();
        tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #2;
        checks++;
        if (cyc1 !== 4'd0 || lst1 !== 4'd0 || frz1 !== 4'd0 || fl1 !== 4'd0 || miss1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters got cyc=%0d ls=%0d fz=%0d fl=%0d miss=%0b want all 0", cyc1, lst1, frz1, fl1, miss1);
        end
        checks++;
        if (ctl1 !== C_RUN || ctl2 !== C_RUN) begin
            errors++;
            $display("FAIL reset_ctl got %b/%b want %b", ctl1, ctl2, C_RUN);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        clearCounters();
        loadUse(5'd5);
        @(negedge muxClockCache);
        checks++;
        if (ctl1 !== C_STALL) begin
            errors++;
            $display("FAIL lu_stall got %b want %b", ctl1, C_STALL);
        end
        tick();
        idle();
        @(negedge muxClockCache);
        checks++;
        if (ctl1 !== C_RUN || lst1 !== 4'd1) begin
            errors++;
            $display("FAIL lu_after got ctl=%b ls=%0d want ctl=%b ls=1", ctl1, lst1, C_RUN);
        end
        tick();
        loadUse(5'd0);
        #1;
        checks++;
        if (ctl1 !== C_RUN) begin
            errors++;
            $display("FAIL lu_x0 got %b want %b", ctl1, C_RUN);
        end
        loadUse(5'd7); rs1_id = 5'd3; rs2_id = 5'd7; use_rs2_id = 1'b1;
        #1;
        checks++;
        if (ctl1 !== C_STALL) begin
            errors++;
            $display("FAIL lu_rs2 got %b want %b", ctl1, C_STALL);
        end
        escreg_ex = 1'b0;
        #1;
        checks++;
        if (ctl1 !== C_RUN) begin
            errors++;
            $display("FAIL lu_noesc got %b want %b", ctl1, C_RUN);
        end
        idle();
    endtask

    task automatic test_lstall_freeze();
        clearCounters();
        loadUse(5'd9);
        @(negedge muxClockCache);
        checks++;
        if (ctl2 !== C_STALL) begin
            errors++;
            $display("FAIL lf_first got %b want %b", ctl2, C_STALL);
        end
        tick();
        idle();
        inst_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge muxClockCache);
            checks++;
            if (ctl2 !== C_FREEZE) begin
                errors++;
                $display("FAIL lf_freeze%0d got %b want %b", i, ctl2, C_FREEZE);
            end
            tick();
        end
        inst_hit = 1'b1;
        @(negedge muxClockCache);
        checks++;
        if (ctl2 !== C_STALL) begin
            errors++;
            $display("FAIL lf_second got %b want %b", ctl2, C_STALL);
        end
        tick();
        @(negedge muxClockCache);
        checks++;
        if (ctl2 !== C_RUN || lst2 !== 16'd2 || frz2 !== 16'd3 || cyc2 !== 16'd5) begin
            errors++;
            $display("FAIL lf_end got ctl=%b ls=%0d fz=%0d cyc=%0d want ctl=%b ls=2 fz=3 cyc=5", ctl2, lst2, frz2, cyc2, C_RUN);
        end
        tick();
    endtask

    task automatic test_redirect();
        clearCounters();
        loadUse(5'd4);
        redirect_mem = 1'b1;
        @(negedge muxClockCache);
        checks++;
        if (ctl1 !== C_REDIR || ctl2 !== C_REDIR) begin
            errors++;
            $display("FAIL rd_flush got %b/%b want %b", ctl1, ctl2, C_REDIR);
        end
        tick();
        idle();
        @(negedge muxClockCache);
        checks++;
        if (ctl2 !== C_RUN || fl1 !== 4'd1 || fl2 !== 16'd1 || lst2 !== 16'd0) begin
            errors++;
            $display("FAIL rd_after got ctl=%b fl=%0d/%0d ls=%0d want ctl=%b fl=1/1 ls=0", ctl2, fl1, fl2, lst2, C_RUN);
        end
        tick();
        redirect_mem = 1'b1;
        data_req = 1'b1;
        data_hit = 1'b0;
        @(negedge muxClockCache);
        checks++;
        if (ctl1 !== C_FREEZE) begin
            errors++;
            $display("FAIL rd_frozen got %b want %b", ctl1, C_FREEZE);
        end
        tick();
        idle();
        @(negedge muxClockCache);
        checks++;
        if (fl1 !== 4'd1 || frz1 !== 4'd1) begin
            errors++;
            $display("FAIL rd_frozen_cnt got fl=%0d fz=%0d want fl=1 fz=1", fl1, frz1);
        end
        tick();
    endtask

    task automatic test_miss_timeout();
        clearCounters();
        data_req = 1'b1;
        data_hit = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        data_hit = 1'b1;
        tick();
        data_hit = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (miss1 !== 1'b0) begin
            errors++;
            $display("FAIL mt_early got %0b want 0", miss1);
        end
        tick();
        checks++;
        if (miss1 !== 1'b1 || miss2 !== 1'b1) begin
            errors++;
            $display("FAIL mt_set got %0b/%0b want 1/1", miss1, miss2);
        end
        data_hit = 1'b1;
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        checks++;
        if (miss1 !== 1'b1 || cyc1 !== 4'd0 || frz1 !== 4'd0) begin
            errors++;
            $display("FAIL mt_sticky got miss=%0b cyc=%0d fz=%0d want miss=1 cyc=0 fz=0", miss1, cyc1, frz1);
        end
        idle();
    endtask

    task automatic test_saturate();
        clearCounters();
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (cyc1 !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got %0d want 15", cyc1);
        end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        checks++;
        if (cyc1 !== 4'd0) begin
            errors++;
            $display("FAIL sat_clr got %0d want 0", cyc1);
        end
        tick();
        checks++;
        if (cyc1 !== 4'd1) begin
            errors++;
            $display("FAIL sat_restart got %0d want 1", cyc1);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        tick();
        loadUse(5'd12);
        tick();
        idle();
        #1;
        checks++;
        if (ctl2 !== C_STALL || lst2 === 16'd0) begin
            errors++;
            $display("FAIL rs_lstall got ctl=%b ls=%0d want ctl=%b ls>0", ctl2, lst2, C_STALL);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cyc2 !== 16'd0 || lst2 !== 16'd0 || frz2 !== 16'd0 || fl2 !== 16'd0 || miss2 !== 1'b0) begin
            errors++;
            $display("FAIL rs_counters got cyc=%0d ls=%0d fz=%0d fl=%0d miss=%0b want all 0", cyc2, lst2, frz2, fl2, miss2);
        end
        checks++;
        if (ctl2 !== C_RUN) begin
            errors++;
            $display("FAIL rs_ctl got %b want %b", ctl2, C_RUN);
        end
        @(negedge muxClockCache);
        reset = 1'b0;
        tick();
        @(negedge muxClockCache);
        checks++;
        if (ctl2 !== C_RUN || cyc2 !== 16'd1) begin
            errors++;
            $display("FAIL rs_release got ctl=%b cyc=%0d want ctl=%b cyc=1", ctl2, cyc2, C_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lstall_freeze();
        test_redirect();
        test_miss_timeout();
        test_saturate();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
